ceas_control_fsm: RTL

Parametrised control block for the digital clock: single-clock successor to the set/run controller. It replaces clock muxing with per-field increment enables and generalises time to NUM_FIELDS binary fields. It adds a programmable alarm register with acknowledge, and a top-of-hour chime of configurable length. It sits between the button debouncers and the time counter chain; its outputs drive the counter enables, the display edit highlight and the buzzer logic.

---
 rtl/ceas_pkg.sv | 21 ++
 rtl/sec_pulse_timer.sv | 51 +++++
 rtl/ceas_control_fsm.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ceas_pkg.sv
// rtl/ceas_pkg.sv - shared state encoding and field helpers for the clock controller
package ceas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SET     = 2'd2,
    ALM_SET = 2'd3
  } ceas_state_e;

  localparam int unsigned HI_MAX_DEF = 23;
  localparam int unsigned LO_MAX_DEF = 59;

  // Only the top field (hours) uses a different wrap limit.
  function automatic int unsigned wrap_limit(input logic        is_top,
                                             input int unsigned hi_max,
                                             input int unsigned lo_max);
    return is_top ? hi_max : lo_max;
  endfunction

endpackage

// File: rtl/sec_pulse_timer.sv
// rtl/sec_pulse_timer.sv - holds active high for N tick pulses after a load
module sec_pulse_timer #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic active_o
);

  localparam int unsigned CW = (N < 2) ? 1 : $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Clear beats load beats tick; a tick in the load cycle is not counted.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (load_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q && tick_i) begin
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/ceas_control_fsm.sv
// rtl/ceas_control_fsm.sv - run/set/alarm-edit controller with alarm register, chime and alarm timers
module ceas_control_fsm
  import ceas_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 3,
  parameter int unsigned FIELD_W    = 8,
  parameter int unsigned HI_MAX     = HI_MAX_DEF,
  parameter int unsigned LO_MAX     = LO_MAX_DEF,
  parameter int unsigned CHIME_SEC  = 2,
  parameter int unsigned ALARM_SEC  = 60
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tick_sec_i,
  input  logic                          btn_start_i,
  input  logic                          btn_set_i,
  input  logic                          btn_alarm_i,
  input  logic                          btn_inc_i,
  input  logic                          alarm_enable_i,
  input  logic [NUM_FIELDS*FIELD_W-1:0] time_in_i,
  output logic                          run_o,
  output logic [NUM_FIELDS-1:0]         inc_en_o,
  output logic [NUM_FIELDS-1:0]         set_field_o,
  output logic                          alarm_edit_o,
  output logic [NUM_FIELDS*FIELD_W-1:0] alarm_value_o,
  output logic                          chime_o,
  output logic                          alarm_o
);

  localparam int unsigned   KW    = (NUM_FIELDS < 2) ? 1 : $clog2(NUM_FIELDS);
  localparam int unsigned   TW    = NUM_FIELDS * FIELD_W;
  localparam logic [KW-1:0] TOP_K = KW'(NUM_FIELDS - 1);

  ceas_state_e           state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [TW-1:0]         alarm_q, alarm_d;
  logic [NUM_FIELDS-1:0] inc_q, inc_d;
  logic                  lowz_q, match_q;

  logic [NUM_FIELDS-1:0] k_onehot;
  logic [FIELD_W-1:0]    cur_field, field_max, next_field;
  logic                  lowz, match, in_run, in_edit;
  logic                  chime_load, chime_clear, alarm_load, alarm_clear;
  logic                  chime_act, alarm_act;

  always_comb begin
    k_onehot = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      k_onehot[i] = (k_q == KW'(i));
    end
  end

  assign cur_field  = alarm_q[k_q*FIELD_W +: FIELD_W];
  assign field_max  = FIELD_W'(wrap_limit(k_q == TOP_K, HI_MAX, LO_MAX));
  assign next_field = (cur_field >= field_max) ? '0 : cur_field + FIELD_W'(1);

  assign lowz    = (time_in_i[TW-FIELD_W-1:0] == '0);
  assign match   = (time_in_i == alarm_q);
  assign in_run  = (state_q == RUN);
  assign in_edit = (state_q == SET) || (state_q == ALM_SET);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    alarm_d = alarm_q;
    inc_d   = '0;
    case (state_q)
      IDLE: begin
        if (btn_start_i) state_d = RUN;
      end
      RUN: begin
        if (btn_set_i) begin
          state_d = SET;
          k_d     = TOP_K;
        end else if (btn_alarm_i) begin
          state_d = ALM_SET;
          k_d     = TOP_K;
        end
      end
      SET: begin
        if (btn_start_i) begin
          state_d = RUN;
        end else if (btn_set_i) begin
          if (k_q == '0) state_d = RUN;
          else           k_d     = k_q - KW'(1);
        end else if (btn_inc_i) begin
          inc_d = k_onehot;
        end
      end
      ALM_SET: begin
        // Seconds of the alarm are never edited, so leave from field 1.
        if (btn_start_i) begin
          state_d = RUN;
        end else if (btn_alarm_i) begin
          if (k_q <= KW'(1)) state_d = RUN;
          else               k_d     = k_q - KW'(1);
        end else if (btn_inc_i) begin
          alarm_d[k_q*FIELD_W +: FIELD_W] = next_field;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      alarm_q <= '0;
      inc_q   <= '0;
      lowz_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      alarm_q <= alarm_d;
      inc_q   <= inc_d;
      lowz_q  <= lowz;
      match_q <= match;
    end
  end

  // Timers are cleared in the same edge that leaves RUN so they drop together with run.
  assign chime_load  = in_run && lowz && !lowz_q;
  assign chime_clear = (state_d != RUN);
  assign alarm_load  = in_run && alarm_enable_i && match && !match_q;
  assign alarm_clear = (state_d != RUN) || (in_run && btn_inc_i && alarm_act);

  sec_pulse_timer #(.N(CHIME_SEC)) u_chime_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (chime_load),
    .tick_i   (tick_sec_i),
    .clear_i  (chime_clear),
    .active_o (chime_act)
  );

  sec_pulse_timer #(.N(ALARM_SEC)) u_alarm_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (alarm_load),
    .tick_i   (tick_sec_i),
    .clear_i  (alarm_clear),
    .active_o (alarm_act)
  );

  always_comb begin
    inc_en_o    = inc_q;
    inc_en_o[0] = inc_q[0] | (in_run & tick_sec_i);
  end

  assign run_o         = in_run;
  assign set_field_o   = in_edit ? k_onehot : '0;
  assign alarm_edit_o  = (state_q == ALM_SET);
  assign alarm_value_o = alarm_q;
  assign chime_o       = chime_act;
  assign alarm_o       = alarm_act;

endmodule
